// File: rtl/cache_status_array.sv
// Per-set, per-way valid/dirty status store with invalidate-all and
// clean-and-invalidate flush; dirty lines are handed to write-back via valid/ready.
module cache_status_array #(
    parameter int INDEXWIDTH = 6,
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int WAYWIDTH   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  web,
    input  logic                  oe,
    input  logic [INDEXWIDTH-1:0] addr_index,
    input  logic [WAYWIDTH-1:0]   way_sel,
    input  logic                  valid_in,
    input  logic                  dirty_in,
    output logic [WAYS-1:0]       valid_out,
    output logic [WAYS-1:0]       dirty_out,
    input  logic                  flush_req,
    input  logic                  flush_mode,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [INDEXWIDTH-1:0] wb_index,
    output logic [WAYWIDTH-1:0]   wb_way
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WB_WAIT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WAYS-1:0]       valid_mem [SETS];
    logic [WAYS-1:0]       dirty_mem [SETS];
    logic [INDEXWIDTH-1:0] set_cnt;
    logic [WAYWIDTH-1:0]   way_cnt;

    logic host_wr;
    logic scan_hit;
    logic last_way;
    logic last_entry;
    logic advance;

    assign valid_out  = oe ? valid_mem[addr_index] : '0;
    assign dirty_out  = oe ? dirty_mem[addr_index] : '0;

    assign flush_busy = (state != IDLE);
    assign flush_done = (state == DONE);
    assign wb_valid   = (state == WB_WAIT);

    always_comb begin
        host_wr    = (state == IDLE) && cs && !web;
        scan_hit   = valid_mem[set_cnt][way_cnt] && dirty_mem[set_cnt][way_cnt];
        last_way   = (way_cnt == WAYWIDTH'(WAYS - 1));
        last_entry = last_way && (set_cnt == INDEXWIDTH'(SETS - 1));
        advance    = ((state == SCAN) && !scan_hit) || ((state == WB_WAIT) && wb_ready);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (flush_req) state_next = flush_mode ? SCAN : DONE;
            SCAN:    if (scan_hit) state_next = WB_WAIT;
                     else if (last_entry) state_next = DONE;
                     else state_next = SCAN;
            WB_WAIT: if (wb_ready) state_next = last_entry ? DONE : SCAN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Scan counters double as the write-back address while parked in WB_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_cnt <= '0;
            way_cnt <= '0;
        end else if ((state == IDLE) && flush_req && flush_mode) begin
            set_cnt <= '0;
            way_cnt <= '0;
        end else if (advance) begin
            way_cnt <= last_way ? '0 : way_cnt + 1'b1;
            if (last_way) set_cnt <= set_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_index <= '0;
            wb_way   <= '0;
        end else if ((state == SCAN) && scan_hit) begin
            wb_index <= set_cnt;
            wb_way   <= way_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ((state == IDLE) && flush_req && !flush_mode)) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (host_wr) begin
                        for (int unsigned w = 0; w < WAYS; w++) begin
                            if (way_sel == WAYWIDTH'(w)) begin
                                valid_mem[addr_index][w] <= valid_in;
                                dirty_mem[addr_index][w] <= dirty_in & valid_in;
                            end
                        end
                    end
                end
                SCAN: begin
                    if (!scan_hit) valid_mem[set_cnt][way_cnt] <= 1'b0;
                end
                WB_WAIT: begin
                    if (wb_ready) begin
                        valid_mem[wb_index][wb_way] <= 1'b0;
                        dirty_mem[wb_index][wb_way] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_status_array.sv
// Directed self-checking bench for cache_status_array (default parameters).
module tb_cache_status_array;

    localparam int IW   = 6;
    localparam int SETS = 64;
    localparam int WAYS = 2;
    localparam int WW   = 1;

    logic            clk;
    logic            rst;
    logic            cs;
    logic            web;
    logic            oe;
    logic [IW-1:0]   addr_index;
    logic [WW-1:0]   way_sel;
    logic            valid_in;
    logic            dirty_in;
    logic [WAYS-1:0] valid_out;
    logic [WAYS-1:0] dirty_out;
    logic            flush_req;
    logic            flush_mode;
    logic            flush_busy;
    logic            flush_done;
    logic            wb_valid;
    logic            wb_ready;
    logic [IW-1:0]   wb_index;
    logic [WW-1:0]   wb_way;

    int checks = 0;
    int errors = 0;

    cache_status_array #(
        .INDEXWIDTH(IW),
        .SETS(SETS),
        .WAYS(WAYS),
        .WAYWIDTH(WW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cs(cs),
        .web(web),
        .oe(oe),
        .addr_index(addr_index),
        .way_sel(way_sel),
        .valid_in(valid_in),
        .dirty_in(dirty_in),
        .valid_out(valid_out),
        .dirty_out(dirty_out),
        .flush_req(flush_req),
        .flush_mode(flush_mode),
        .flush_busy(flush_busy),
        .flush_done(flush_done),
        .wb_valid(wb_valid),
        .wb_ready(wb_ready),
        .wb_index(wb_index),
        .wb_way(wb_way)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic host_write(input int idx, input int w, input logic v, input logic d);
        @(negedge clk);
        cs = 1'b1; web = 1'b0;
        addr_index = IW'(idx); way_sel = WW'(w); valid_in = v; dirty_in = d;
        @(negedge clk);
        cs = 1'b0; web = 1'b1;
    endtask

    // Reads every set; only legal while the FSM is idle and no write is pending.
    task automatic count_nonzero(output int n);
        n = 0;
        oe = 1'b1;
        for (int s = 0; s < SETS; s++) begin
            addr_index = IW'(s);
            #1;
            if (valid_out !== '0 || dirty_out !== '0) n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", flush_busy); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", flush_done); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        checks++; if (wb_index !== '0 || wb_way !== '0) begin errors++; $display("FAIL reset_wb_addr: got %0d/%0d want 0/0", wb_index, wb_way); end
        count_nonzero(n);
        checks++; if (n !== 0) begin errors++; $display("FAIL reset_array: got %0d nonzero sets want 0", n); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        host_write(5, 1, 1'b1, 1'b1);
        oe = 1'b1; addr_index = 6'd5; #1;
        checks++; if (valid_out !== 2'b10 || dirty_out !== 2'b10) begin errors++; $display("FAIL wr_set5: got v=%b d=%b want v=10 d=10", valid_out, dirty_out); end
        oe = 1'b0; #1;
        checks++; if (valid_out !== 2'b00 || dirty_out !== 2'b00) begin errors++; $display("FAIL oe_low: got v=%b d=%b want 00 00", valid_out, dirty_out); end
        oe = 1'b1;
        host_write(3, 0, 1'b0, 1'b1);
        addr_index = 6'd3; #1;
        checks++; if (valid_out !== 2'b00 || dirty_out !== 2'b00) begin errors++; $display("FAIL dirty_masked: got v=%b d=%b want 00 00", valid_out, dirty_out); end
        host_write(3, 1, 1'b1, 1'b0);
        addr_index = 6'd3; #1;
        checks++; if (valid_out !== 2'b10 || dirty_out !== 2'b00) begin errors++; $display("FAIL clean_line: got v=%b d=%b want 10 00", valid_out, dirty_out); end
        host_write(5, 0, 1'b1, 1'b0);
        addr_index = 6'd5; #1;
        checks++; if (valid_out !== 2'b11 || dirty_out !== 2'b10) begin errors++; $display("FAIL second_way: got v=%b d=%b want 11 10", valid_out, dirty_out); end
        @(negedge clk);
        cs = 1'b0; web = 1'b0; addr_index = 6'd6; way_sel = 1'b0; valid_in = 1'b1; dirty_in = 1'b1;
        @(negedge clk);
        cs = 1'b1; web = 1'b1;
        @(negedge clk);
        cs = 1'b0; #1;
        checks++; if (valid_out !== 2'b00 || dirty_out !== 2'b00) begin errors++; $display("FAIL no_select: got v=%b d=%b want 00 00", valid_out, dirty_out); end
    endtask

    task automatic test_invalidate_all;
        int n;
        host_write(20, 0, 1'b1, 1'b1);
        host_write(63, 1, 1'b1, 1'b0);
        @(negedge clk);
        flush_req = 1'b1; flush_mode = 1'b0;
        cs = 1'b1; web = 1'b0; addr_index = 6'd7; way_sel = 1'b1; valid_in = 1'b1; dirty_in = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        checks++; if (flush_done !== 1'b1 || flush_busy !== 1'b1) begin errors++; $display("FAIL inv_done: got done=%b busy=%b want 1 1", flush_done, flush_busy); end
        addr_index = 6'd8; way_sel = 1'b0;
        @(negedge clk);
        cs = 1'b0; web = 1'b1;
        checks++; if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin errors++; $display("FAIL inv_idle: got done=%b busy=%b want 0 0", flush_done, flush_busy); end
        count_nonzero(n);
        checks++; if (n !== 0) begin errors++; $display("FAIL inv_array: got %0d nonzero sets want 0", n); end
    endtask

    task automatic test_clean_no_dirty;
        int n, done_at, saw_wb;
        host_write(4, 1, 1'b1, 1'b0);
        host_write(63, 0, 1'b1, 1'b0);
        @(negedge clk);
        flush_req = 1'b1; flush_mode = 1'b1;
        n = 0; done_at = 0; saw_wb = 0;
        while (n < 300 && done_at == 0) begin
            @(negedge clk);
            n++;
            flush_req = 1'b0; cs = 1'b0; web = 1'b1;
            if (n == 1) begin
                checks++; if (flush_busy !== 1'b1 || flush_done !== 1'b0) begin errors++; $display("FAIL scan_start: got busy=%b done=%b want 1 0", flush_busy, flush_done); end
            end
            if (n == 2) begin
                cs = 1'b1; web = 1'b0; addr_index = 6'd40; way_sel = 1'b0; valid_in = 1'b1; dirty_in = 1'b1;
            end
            if (n == 3) begin
                oe = 1'b1; addr_index = 6'd40; #1;
                checks++; if (valid_out !== 2'b00 || dirty_out !== 2'b00) begin errors++; $display("FAIL busy_write: got v=%b d=%b want 00 00", valid_out, dirty_out); end
            end
            if (wb_valid === 1'b1) saw_wb = 1;
            if (flush_done === 1'b1) done_at = n;
        end
        checks++; if (done_at !== 129) begin errors++; $display("FAIL clean_nodirty_time: got %0d want 129", done_at); end
        checks++; if (saw_wb !== 0) begin errors++; $display("FAIL clean_nodirty_wb: got %0d want 0", saw_wb); end
        @(negedge clk);
        checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL clean_nodirty_idle: got %b want 0", flush_busy); end
        count_nonzero(n);
        checks++; if (n !== 0) begin errors++; $display("FAIL clean_nodirty_array: got %0d nonzero sets want 0", n); end
    endtask

    task automatic test_clean_dirty;
        int n, done_at, hs;
        int got_idx [3];
        int got_way [3];
        int exp_idx [3] = '{2, 2, 63};
        int exp_way [3] = '{0, 1, 1};
        host_write(2, 0, 1'b1, 1'b1);
        host_write(2, 1, 1'b1, 1'b1);
        host_write(63, 1, 1'b1, 1'b1);
        host_write(5, 0, 1'b1, 1'b0);
        wb_ready = 1'b1;
        @(negedge clk);
        flush_req = 1'b1; flush_mode = 1'b1;
        n = 0; done_at = 0; hs = 0;
        while (n < 400 && done_at == 0) begin
            @(negedge clk);
            n++;
            flush_req = 1'b0;
            if (wb_valid === 1'b1) begin
                if (hs < 3) begin
                    got_idx[hs] = int'(wb_index);
                    got_way[hs] = int'(wb_way);
                end
                hs++;
            end
            if (flush_done === 1'b1) done_at = n;
        end
        checks++; if (hs !== 3) begin errors++; $display("FAIL wb_count: got %0d want 3", hs); end
        for (int i = 0; i < 3; i++) begin
            if (i < hs) begin
                checks++;
                if (got_idx[i] !== exp_idx[i] || got_way[i] !== exp_way[i]) begin
                    errors++; $display("FAIL wb_order%0d: got (%0d,%0d) want (%0d,%0d)", i, got_idx[i], got_way[i], exp_idx[i], exp_way[i]);
                end
            end
        end
        checks++; if (done_at !== 132) begin errors++; $display("FAIL clean_dirty_time: got %0d want 132", done_at); end
        @(negedge clk);
        count_nonzero(n);
        checks++; if (n !== 0) begin errors++; $display("FAIL clean_dirty_array: got %0d nonzero sets want 0", n); end
    endtask

    task automatic test_wb_stall;
        int n;
        host_write(2, 0, 1'b1, 1'b1);
        host_write(2, 1, 1'b1, 1'b1);
        host_write(63, 1, 1'b1, 1'b1);
        wb_ready = 1'b0;
        @(negedge clk);
        flush_req = 1'b1; flush_mode = 1'b1;
        n = 0;
        while (n < 20 && wb_valid !== 1'b1) begin
            @(negedge clk);
            flush_req = 1'b0;
            n++;
        end
        checks++; if (wb_valid !== 1'b1 || wb_index !== 6'd2 || wb_way !== 1'b0) begin errors++; $display("FAIL stall_first: got v=%b (%0d,%0d) want 1 (2,0)", wb_valid, wb_index, wb_way); end
        repeat (10) begin
            @(negedge clk);
            checks++; if (wb_valid !== 1'b1 || wb_index !== 6'd2 || wb_way !== 1'b0) begin errors++; $display("FAIL stall_hold: got v=%b (%0d,%0d) want 1 (2,0)", wb_valid, wb_index, wb_way); end
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", wb_valid); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || wb_index !== 6'd2 || wb_way !== 1'b1) begin errors++; $display("FAIL stall_next: got v=%b (%0d,%0d) want 1 (2,1)", wb_valid, wb_index, wb_way); end
    endtask

    task automatic test_reset_in_wb;
        int n, done_at;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (wb_valid !== 1'b0 || flush_busy !== 1'b0) begin errors++; $display("FAIL rst_wb: got wb_valid=%b busy=%b want 0 0", wb_valid, flush_busy); end
        checks++; if (wb_index !== '0 || wb_way !== '0) begin errors++; $display("FAIL rst_wb_addr: got (%0d,%0d) want (0,0)", wb_index, wb_way); end
        count_nonzero(n);
        checks++; if (n !== 0) begin errors++; $display("FAIL rst_wb_array: got %0d nonzero sets want 0", n); end
        host_write(0, 0, 1'b1, 1'b1);
        host_write(1, 1, 1'b1, 1'b1);
        @(negedge clk);
        flush_req = 1'b1; flush_mode = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        checks++; if (wb_valid !== 1'b0 || flush_busy !== 1'b1) begin errors++; $display("FAIL restart_scan: got wb_valid=%b busy=%b want 0 1", wb_valid, flush_busy); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || wb_index !== 6'd0 || wb_way !== 1'b0) begin errors++; $display("FAIL restart_origin: got v=%b (%0d,%0d) want 1 (0,0)", wb_valid, wb_index, wb_way); end
        wb_ready = 1'b1;
        n = 2; done_at = 0;
        while (n < 400 && done_at == 0) begin
            @(negedge clk);
            n++;
            if (flush_done === 1'b1) done_at = n;
        end
        checks++; if (done_at !== 131) begin errors++; $display("FAIL restart_time: got %0d want 131", done_at); end
        @(negedge clk);
        count_nonzero(n);
        checks++; if (n !== 0) begin errors++; $display("FAIL restart_array: got %0d nonzero sets want 0", n); end
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; web = 1'b1; oe = 1'b0;
        addr_index = '0; way_sel = '0; valid_in = 1'b0; dirty_in = 1'b0;
        flush_req = 1'b0; flush_mode = 1'b0; wb_ready = 1'b0;
        test_reset();
        test_write_read();
        test_invalidate_all();
        test_clean_no_dirty();
        test_clean_dirty();
        test_wb_stall();
        test_reset_in_wb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
